mem_store_ctrl: RTL and testbench
=================================

MEM_STORE_CTRL -- requirements
Module: mem_store_ctrl

Interface
REQ-001 SHALL have ports: iCLK  in  1  sole clock, rising edge; iRST  in  1  reset, synchronous, active-high.
REQ-002 SHALL have request ports: iValid  in  1  store request; oReady  out  1  request accepted when iValid&&oReady; iFunct3  in  3  store type (SB=000, SH=001, SW=010); iAddress  in  32  byte address; iData  in  32  store data (low byte/half/word significant).
REQ-003 SHALL have memory ports: oMemWrite  out  1  write request; oMemAddress  out  32  word-aligned address (bits[1:0]=00); oMemWriteData  out  32  lane-positioned data; oMemByteEnable  out  4  lane enables; iMemAck  in  1  write completed this cycle.
REQ-004 SHALL have status ports: oDone  out  1  one-cycle completion pulse; oException  out  1  one-cycle misaligned/illegal pulse, coincident with oDone.

Function
REQ-005 SHALL implement states IDLE, WR0, WR1; oReady=1 only in IDLE.
REQ-006 SHALL on acceptance register funct3, address and data; further iValid ignored until return to IDLE.
REQ-007 SHALL compute a = iAddress[1:0]; mask = 0001 (SB), 0011 (SH), 1111 (SW); 8-bit enable vector E = mask<<a; 64-bit data vector D = {32'b0, data}<<(8*a).
REQ-008 SHALL classify request as illegal when funct3 is not 000/001/010; illegal -> no memory write, oException=oDone=1 the cycle after acceptance, return to IDLE.
REQ-009 SHALL classify request as misaligned when E[7:4]!=0 (SH a=3; SW a!=0) or, with MISALIGNED_SPLIT_EN undefined, also SH a=1.
REQ-010 SHALL for aligned legal requests enter WR0 the cycle after acceptance: oMemWrite=1, oMemAddress={addr[31:2],2'b00}, oMemByteEnable=E[3:0], oMemWriteData=D[31:0].
REQ-011 SHALL hold oMemWrite, address, data, byte-enable stable in WR0/WR1 until iMemAck sampled 1; wait unbounded.
REQ-012 SHALL on iMemAck in WR0 (no second access pending) drop oMemWrite and pulse oDone next cycle, returning to IDLE; oReady=1 in that same cycle.
REQ-013 SHALL on iMemAck in WR1 behave as REQ-012.
REQ-014 SHALL ignore iMemAck in IDLE.
REQ-015 SHALL give latency: acceptance at cycle N, oMemWrite at N+1, with ack at N+1 oDone at N+2 (single access); split with immediate acks oDone at N+3.
REQ-016 SHALL wrap the second-access address modulo 2^32 (0xFFFFFFFC -> 0x00000000).
REQ-017 SHALL drive oDone and oException as single-cycle pulses, never both oException and oMemWrite in the same request.

Reset
REQ-018 SHALL on iRST at a rising edge force IDLE, oReady=1, oMemWrite=0, oMemAddress=0, oMemWriteData=0, oMemByteEnable=0, oDone=0, oException=0.
REQ-019 SHALL abort any in-flight access on reset with no oDone; a pending iMemAck during reset is ignored.
REQ-020 SHALL take iRST priority over iValid and iMemAck in the same cycle.

Configuration
REQ-021 SHALL honor macro MISALIGNED_SPLIT_EN.
REQ-022 SHALL without MISALIGNED_SPLIT_EN treat every misaligned request (REQ-009) as exception: no write, oException=oDone=1 at N+1.
REQ-023 SHALL with MISALIGNED_SPLIT_EN perform SH a=1 as single WR0 access (E=0110), and for E[7:4]!=0 perform WR0 (E[3:0], D[31:0], base word) then WR1 (E[7:4], D[63:32], base+4), oException never asserted for misalignment.
REQ-024 SHALL treat illegal funct3 per REQ-008 in both configurations.

Verification
REQ-025 SB addr 0x00000103 data 0x000000A5, ack immediate -> addr 0x00000100, BE 1000, data[31:24]=A5, oDone at N+2.
REQ-026 SW addr 0x00000200 data 0xDEADBEEF, ack delayed 3 cycles -> outputs stable 4 cycles, BE 1111, oDone cycle after ack.
REQ-027 SW addr 0x00000102 data 0x11223344, split on -> WR0 0x100 BE 1100 data 0x33440000; WR1 0x104 BE 0011 data 0x00001122; split off -> no write, oException=oDone=1 at N+1.
REQ-028 SH addr 0xFFFFFFFF data 0xABCD, split on -> WR0 0xFFFFFFFC BE 1000 data 0xCD000000; WR1 0x00000000 BE 0001 data 0x000000AB.
REQ-029 funct3=011 addr 0x0 -> oException=oDone=1 at N+1, oMemWrite never 1.
REQ-030 iRST asserted in WR1 while iMemAck=1 -> next cycle IDLE, all outputs per REQ-018, no oDone.

Source files
------------

// File: rtl/mem_store_ctrl.sv
// Store controller: turns SB/SH/SW requests into lane-positioned word writes.
// Optional macro MISALIGNED_SPLIT_EN splits word-crossing stores into two accesses.
module mem_store_ctrl (
  input  logic        iCLK,
  input  logic        iRST,
  input  logic        iValid,
  output logic        oReady,
  input  logic [2:0]  iFunct3,
  input  logic [31:0] iAddress,
  input  logic [31:0] iData,
  output logic        oMemWrite,
  output logic [31:0] oMemAddress,
  output logic [31:0] oMemWriteData,
  output logic [3:0]  oMemByteEnable,
  input  logic        iMemAck,
  output logic        oDone,
  output logic        oException
);

  typedef enum logic [1:0] {IDLE, WR0, WR1} state_t;

  state_t      state;
  logic [1:0]  offset;
  logic [3:0]  mask;
  logic [7:0]  laneEn;
  logic [63:0] laneData;
  logic        illegal;
  logic        crossWord;
  logic        reject;
  logic        hiPending;
  logic [31:0] hiAddress;
  logic [31:0] hiData;
  logic [3:0]  hiEnable;
  logic [31:0] baseAddress;

  assign oReady = (state == IDLE);

  // Request decode: lane enables and data positioned across two adjacent words
  always_comb begin
    offset  = iAddress[1:0];
    illegal = 1'b0;
    case (iFunct3)
      3'b000:  mask = 4'b0001;
      3'b001:  mask = 4'b0011;
      3'b010:  mask = 4'b1111;
      default: begin
        mask    = 4'b0000;
        illegal = 1'b1;
      end
    endcase
    laneEn      = {4'b0000, mask} << offset;
    laneData    = {32'd0, iData} << {offset, 3'b000};
    crossWord   = |laneEn[7:4];
    baseAddress = {iAddress[31:2], 2'b00};
`ifdef MISALIGNED_SPLIT_EN
    reject = illegal;
`else
    reject = illegal | crossWord | ((iFunct3 == 3'b001) && (offset == 2'd1));
`endif
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state          <= IDLE;
      oMemWrite      <= 1'b0;
      oMemAddress    <= 32'd0;
      oMemWriteData  <= 32'd0;
      oMemByteEnable <= 4'd0;
      oDone          <= 1'b0;
      oException     <= 1'b0;
      hiPending      <= 1'b0;
    end else begin
      oDone      <= 1'b0;
      oException <= 1'b0;
      case (state)
        IDLE: begin
          if (iValid) begin
            if (reject) begin
              oDone      <= 1'b1;
              oException <= 1'b1;
            end else begin
              state          <= WR0;
              oMemWrite      <= 1'b1;
              oMemAddress    <= baseAddress;
              oMemByteEnable <= laneEn[3:0];
              oMemWriteData  <= laneData[31:0];
              hiPending      <= crossWord;
            end
          end
        end
        WR0: begin
          if (iMemAck) begin
            if (hiPending) begin
              state          <= WR1;
              oMemAddress    <= hiAddress;
              oMemByteEnable <= hiEnable;
              oMemWriteData  <= hiData;
              hiPending      <= 1'b0;
            end else begin
              state     <= IDLE;
              oMemWrite <= 1'b0;
              oDone     <= 1'b1;
            end
          end
        end
        WR1: begin
          if (iMemAck) begin
            state     <= IDLE;
            oMemWrite <= 1'b0;
            oDone     <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Second-word payload is only consumed while hiPending is set, so it needs no reset
  always_ff @(posedge iCLK) begin
    if ((state == IDLE) && iValid) begin
      hiAddress <= baseAddress + 32'd4;
      hiEnable  <= laneEn[7:4];
      hiData    <= laneData[63:32];
    end
  end

endmodule

// File: tb/tb_mem_store_ctrl.sv
// Scoreboard bench for mem_store_ctrl: byte-level reference model feeds an
// expectation queue; a negedge monitor checks writes, completions and timing.
module tb_mem_store_ctrl;

`ifdef MISALIGNED_SPLIT_EN
  localparam bit SPLIT = 1'b1;
`else
  localparam bit SPLIT = 1'b0;
`endif

  logic        iCLK = 1'b0;
  logic        iRST = 1'b1;
  logic        iValid = 1'b0;
  logic        oReady;
  logic [2:0]  iFunct3 = 3'b000;
  logic [31:0] iAddress = 32'd0;
  logic [31:0] iData = 32'd0;
  logic        oMemWrite;
  logic [31:0] oMemAddress;
  logic [31:0] oMemWriteData;
  logic [3:0]  oMemByteEnable;
  logic        iMemAck = 1'b0;
  logic        oDone;
  logic        oException;

  mem_store_ctrl dut (
    .iCLK(iCLK), .iRST(iRST), .iValid(iValid), .oReady(oReady),
    .iFunct3(iFunct3), .iAddress(iAddress), .iData(iData),
    .oMemWrite(oMemWrite), .oMemAddress(oMemAddress), .oMemWriteData(oMemWriteData),
    .oMemByteEnable(oMemByteEnable), .iMemAck(iMemAck),
    .oDone(oDone), .oException(oException)
  );

  always #5 iCLK = ~iCLK;

  typedef struct {
    bit          isWrite;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] data;
    bit          exc;
  } item_t;

  item_t sbq[$];
  int    errors = 0;
  int    checks = 0;
  int    cyc = 0;
  int    refCycle = 0;
  bit    presenting = 1'b0;
  int    forcedDelay = -1;
  bit    ackManual = 1'b0;

  always @(posedge iCLK) cyc <= cyc + 1;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Reference: the store writes `size` consecutive bytes starting at a; bytes
  // are grouped by the word they land in. Rejected requests yield only a done/exception.
  function automatic void model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] d);
    int size;
    int lane;
    bit hasW1;
    logic [31:0] ba;
    logic [31:0] base0;
    item_t w0, w1, dn;
    size  = (f == 3'b000) ? 1 : (f == 3'b001) ? 2 : (f == 3'b010) ? 4 : 0;
    hasW1 = 1'b0;
    dn = '{isWrite:1'b0, addr:32'h0, be:4'h0, data:32'h0, exc:1'b0};
    if (size == 0 || (!SPLIT && (a % 32'(size)) != 0)) begin
      dn.exc = 1'b1;
      sbq.push_back(dn);
      return;
    end
    base0 = a & 32'hFFFF_FFFC;
    w0 = '{isWrite:1'b1, addr:base0, be:4'h0, data:32'h0, exc:1'b0};
    w1 = '{isWrite:1'b1, addr:base0 + 32'd4, be:4'h0, data:32'h0, exc:1'b0};
    for (int i = 0; i < size; i++) begin
      ba   = a + 32'(i);
      lane = int'(ba[1:0]);
      if ((ba & 32'hFFFF_FFFC) == base0) begin
        w0.be[lane] = 1'b1;
        w0.data[8*lane +: 8] = d[8*i +: 8];
      end else begin
        hasW1 = 1'b1;
        w1.be[lane] = 1'b1;
        w1.data[8*lane +: 8] = d[8*i +: 8];
      end
    end
    sbq.push_back(w0);
    if (hasW1) sbq.push_back(w1);
    sbq.push_back(dn);
  endfunction

  // Monitor: every presented write / completion is matched against the queue front
  always @(negedge iCLK) begin
    item_t e;
    if (iRST) begin
      sbq.delete();
      presenting = 1'b0;
    end else begin
      if (oException) chk("exc_needs_done", oDone, 1'b1);
      if (oException) chk("exc_with_write", oMemWrite, 1'b0);
      if (oMemWrite === 1'b1) begin
        if (sbq.size() == 0) begin
          chk("unexpected_write", oMemWrite, 1'b0);
        end else begin
          e = sbq[0];
          if (!presenting) chk("write_latency", cyc, refCycle + 1);
          chk("write_kind", 32'(e.isWrite), 32'd1);
          chk("mem_addr", oMemAddress, e.addr);
          chk("mem_be", oMemByteEnable, e.be);
          chk("mem_data", oMemWriteData, e.data);
          presenting = 1'b1;
          if (iMemAck) begin
            void'(sbq.pop_front());
            presenting = 1'b0;
            refCycle   = cyc;
          end
        end
      end
      if (oDone === 1'b1) begin
        if (sbq.size() == 0) begin
          chk("unexpected_done", oDone, 1'b0);
        end else begin
          e = sbq.pop_front();
          chk("done_latency", cyc, refCycle + 1);
          chk("done_kind", 32'(e.isWrite), 32'd0);
          chk("exception", oException, e.exc);
        end
      end
      if (iValid && oReady) refCycle = cyc;
    end
  end

  // Memory model: acks after a random or forced number of wait cycles; random acks while idle
  initial begin : ackDriver
    int waitCnt;
    int target;
    bit lastAck;
    waitCnt = 0;
    target  = 0;
    lastAck = 1'b0;
    forever begin
      @(posedge iCLK);
      #1;
      if (!ackManual) begin
        if (lastAck || oMemWrite !== 1'b1) begin
          waitCnt = 0;
          target  = (forcedDelay >= 0) ? forcedDelay : int'($urandom_range(0, 3));
        end
        if (oMemWrite === 1'b1) begin
          iMemAck = (waitCnt >= target);
          waitCnt++;
        end else begin
          iMemAck = 1'($urandom_range(0, 1));
        end
        lastAck = (oMemWrite === 1'b1) && iMemAck;
      end
    end
  end

  task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] d);
    int guard;
    guard = 0;
    model(f, a, d);
    iValid = 1'b1; iFunct3 = f; iAddress = a; iData = d;
    while (oReady !== 1'b1 && guard < 200) begin
      @(posedge iCLK); #1;
      guard++;
    end
    if (guard >= 200) chk("ready_timeout", 32'(guard), 32'd0);
    @(posedge iCLK); #1;
    iValid   = 1'b0;
    iFunct3  = 3'($urandom);
    iAddress = $urandom;
    iData    = $urandom;
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while (sbq.size() != 0 && guard < 200) begin
      @(posedge iCLK); #1;
      guard++;
    end
    if (guard >= 200) chk("drain_timeout", 32'(sbq.size()), 32'd0);
  endtask

  typedef struct {
    logic [2:0]  f;
    logic [31:0] a;
    logic [31:0] d;
    int          delay;
  } vec_t;

  vec_t dirVecs[8];

  initial begin
    logic [2:0]  f;
    logic [31:0] a;
    logic [31:0] d;
    int          pick;

    dirVecs[0] = '{f:3'b000, a:32'h0000_0103, d:32'h0000_00A5, delay:0};
    dirVecs[1] = '{f:3'b010, a:32'h0000_0200, d:32'hDEAD_BEEF, delay:3};
    dirVecs[2] = '{f:3'b010, a:32'h0000_0102, d:32'h1122_3344, delay:0};
    dirVecs[3] = '{f:3'b001, a:32'hFFFF_FFFF, d:32'h0000_ABCD, delay:0};
    dirVecs[4] = '{f:3'b011, a:32'h0000_0000, d:32'h1234_5678, delay:0};
    dirVecs[5] = '{f:3'b001, a:32'h0000_0101, d:32'h0000_BEEF, delay:1};
    dirVecs[6] = '{f:3'b111, a:32'h0000_0004, d:32'h0000_0001, delay:0};
    dirVecs[7] = '{f:3'b010, a:32'hFFFF_FFFD, d:32'hCAFE_F00D, delay:2};

    repeat (3) @(posedge iCLK);
    #1;
    chk("rst_ready", oReady, 1'b1);
    chk("rst_write", oMemWrite, 1'b0);
    chk("rst_addr", oMemAddress, 32'h0);
    chk("rst_data", oMemWriteData, 32'h0);
    chk("rst_be", oMemByteEnable, 4'h0);
    chk("rst_done", oDone, 1'b0);
    chk("rst_exc", oException, 1'b0);
    iRST = 1'b0;

    for (int i = 0; i < 8; i++) begin
      forcedDelay = dirVecs[i].delay;
      @(posedge iCLK); #1;
      issue(dirVecs[i].f, dirVecs[i].a, dirVecs[i].d);
      drain();
    end
    forcedDelay = -1;

    for (int n = 0; n < 300; n++) begin
      pick = int'($urandom_range(0, 9));
      f = (pick > 7) ? 3'b010 : 3'(pick);
      a = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFFC | 32'($urandom_range(0, 3))) : $urandom;
      d = $urandom;
      if (f == 3'b000) d = d & 32'h0000_00FF;
      if (f == 3'b001) d = d & 32'h0000_FFFF;
      issue(f, a, d);
      repeat ($urandom_range(0, 2)) begin
        @(posedge iCLK); #1;
      end
    end
    drain();

    // Reset while an access is in flight (second word when splitting) with ack raised
    ackManual = 1'b1;
    @(posedge iCLK); #1;
    iMemAck = 1'b0;
    if (SPLIT) model(3'b010, 32'h0000_0102, 32'h1122_3344);
    else       model(3'b000, 32'h0000_0100, 32'h0000_0044);
    iValid   = 1'b1;
    iFunct3  = SPLIT ? 3'b010 : 3'b000;
    iAddress = SPLIT ? 32'h0000_0102 : 32'h0000_0100;
    iData    = SPLIT ? 32'h1122_3344 : 32'h0000_0044;
    @(posedge iCLK); #1;
    iValid = 1'b0;
    chk("pre_rst_write", oMemWrite, 1'b1);
    if (SPLIT) begin
      iMemAck = 1'b1;
      @(posedge iCLK); #1;
      chk("pre_rst_wr1_addr", oMemAddress, 32'h0000_0104);
    end
    iRST = 1'b1; iMemAck = 1'b1;
    iValid = 1'b1; iFunct3 = 3'b010; iAddress = 32'h0000_0200; iData = 32'h5555_AAAA;
    @(posedge iCLK); #1;
    iRST = 1'b0; iMemAck = 1'b0; iValid = 1'b0;
    chk("abort_ready", oReady, 1'b1);
    chk("abort_write", oMemWrite, 1'b0);
    chk("abort_addr", oMemAddress, 32'h0);
    chk("abort_data", oMemWriteData, 32'h0);
    chk("abort_be", oMemByteEnable, 4'h0);
    chk("abort_done", oDone, 1'b0);
    chk("abort_exc", oException, 1'b0);
    @(posedge iCLK); #1;
    chk("abort_done_next", oDone, 1'b0);
    chk("abort_write_next", oMemWrite, 1'b0);
    chk("abort_queue", 32'(sbq.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
